fir_coeff_ctrl: RTL and testbench
=================================

# fir_coeff_ctrl

Coefficient configuration controller for the 64-tap parallel FIR adder tree. It accepts a new coefficient set over a valid/ready stream into a shadow bank and holds the datapath's current coefficients in an active bank. On a sample boundary it swaps the banks atomically and can optionally flush the datapath delay line. It sits between the host/config interface and the FIR datapath's coefficient inputs, so coefficients can be retuned live without glitching a sample.

## Interface
- `ORDER`, 64: number of taps; coefficients per set.
- `COEFF_W`, 32: signed coefficient width.
- `CNT_W`, 7: width of beat counter; must satisfy 2^CNT_W > ORDER.

- `clk`  in  1  rising-edge clock, single domain.
- `reset`  in  1  asynchronous, active-low reset; low clears all state immediately.
- `cfg_valid`  in  1  coefficient beat valid.
- `cfg_ready`  out  1  controller accepts beat; depends on state only, never on `cfg_valid`.
- `cfg_data`  in  COEFF_W  signed coefficient; beat k is written to tap k.
- `cfg_last`  in  1  marks final beat of a set.
- `sample_strobe`  in  1  high for the cycle a new sample enters the FIR delay line.
- `flush_en`  in  1  if high when the swap occurs, request delay-line flush.
- `coeff_bus`  out  ORDER*COEFF_W  active-bank coefficients; tap k at bits [k*COEFF_W +: COEFF_W].
- `bank_sel`  out  1  index of active bank.
- `flush`  out  1  one-cycle pulse: datapath clears delay line.
- `swap_done`  out  1  one-cycle pulse: new set is live.
- `cfg_err`  out  1  one-cycle pulse: malformed set rejected.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Beat accepted = `cfg_valid & cfg_ready` at a rising edge.
- Two banks of ORDER x COEFF_W registers. The shadow bank is `~bank_sel`. `coeff_bus` is a combinational mux of the active bank by `bank_sel`.
- States:
  - IDLE: `cfg_ready`=1. An accepted beat writes shadow[0] and sets cnt=1.
    - If that beat has `cfg_last` and ORDER==1, go to ARMED.
    - If it has `cfg_last` otherwise, pulse `cfg_err` and stay in IDLE.
    - Otherwise go to LOAD.
  - LOAD: `cfg_ready`=1. An accepted beat writes shadow[cnt] and sets cnt+=1.
    - Beat with `cfg_last` and cnt+1==ORDER: go to ARMED.
    - Beat with `cfg_last` and cnt+1<ORDER: pulse `cfg_err`, go to IDLE.
    - Beat without `cfg_last` and cnt+1==ORDER: pulse `cfg_err`, go to DRAIN.
  - DRAIN: `cfg_ready`=1. Beats are discarded with no write. A beat with `cfg_last` returns to IDLE with no further `cfg_err`.
  - ARMED: `cfg_ready`=0. Wait for `sample_strobe`. On strobe:
    - toggle `bank_sel`;
    - pulse `swap_done`;
    - pulse `flush` iff `flush_en` is high that cycle;
    - go to IDLE.
- Rejected sets never alter the active bank. Partial shadow contents are overwritten by the next load.
- `cnt` resets to 0 on every entry to IDLE.

## Timing
- Reset values: all coefficient registers 0, `bank_sel`=0, state IDLE, `cfg_ready`=1, `busy`=0, `flush`/`swap_done`/`cfg_err`=0, `coeff_bus`=0.
- `flush`, `swap_done` and `cfg_err` are registered. Each is high for exactly the cycle after the triggering edge.
- Minimum load is ORDER cycles at full throughput. Bubbles on `cfg_valid` are allowed anywhere.
- Swap latency:
  - strobe sampled in ARMED at edge t;
  - `bank_sel` and `coeff_bus` take new values in cycle t+1, together with `swap_done` and `flush`.
- If `sample_strobe` coincides with the edge that accepts `cfg_last` (LOAD to ARMED), there is no swap. The next strobe performs it.
- `sample_strobe` in IDLE, LOAD or DRAIN is ignored.
- `reset` low mid-load or in ARMED: immediate return to reset values. Both banks are cleared and any pending swap is lost.
- `coeff_bus` changes only on a swap edge or at reset.

## Test plan
- **Reset:** after reset release → `coeff_bus`=0, `bank_sel`=0, `cfg_ready`=1, `busy`=0.
- **Full load and swap:** stream beats with values 1..64, `cfg_last` on beat 64, then pulse `sample_strobe` with `flush_en`=1 → `bank_sel`=1, tap k = k+1, `swap_done` and `flush` each high for 1 cycle, state IDLE.
- **Short set:** `cfg_last` on beat 10 → `cfg_err` pulses once, `bank_sel` and `coeff_bus` unchanged. A following full load succeeds.
- **Long set:** 70 beats with `cfg_last` on beat 70 → `cfg_err` pulses after beat 64, beats 65–70 are accepted and discarded, return to IDLE, active bank unchanged.
- **Coincident strobe:** `sample_strobe` high in the same cycle as `cfg_last` acceptance → no swap that cycle. The next strobe swaps. `flush_en`=0 → `flush` stays 0.
- **Reset mid-load:** assert `reset` low after beat 30, release, then load set B → after swap `coeff_bus` equals B exactly, `bank_sel`=1.

Source files
------------

// File: rtl/fir_coeff_ctrl.sv
// rtl/fir_coeff_ctrl.sv - double-banked FIR coefficient loader with sample-aligned swap
module fir_coeff_ctrl #(
  parameter int ORDER   = 64,
  parameter int COEFF_W = 32,
  parameter int CNT_W   = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [COEFF_W-1:0]         cfg_data,
  input  logic                       cfg_last,
  input  logic                       sample_strobe,
  input  logic                       flush_en,
  output logic [ORDER*COEFF_W-1:0]   coeff_bus,
  output logic                       bank_sel,
  output logic                       flush,
  output logic                       swap_done,
  output logic                       cfg_err,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_ARMED} state_t;

  localparam int IDX_W = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ORDER);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COEFF_W-1:0] r_bank0 [ORDER];
  logic [COEFF_W-1:0] r_bank1 [ORDER];
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_loading;
  logic               w_full;
  logic               w_wr;
  logic               w_set_err;
  logic               w_swap;
  logic               r_bank_sel;
  logic               r_flush;
  logic               r_swap_done;
  logic               r_cfg_err;

  // IDLE is simply LOAD with cnt==0, so both share the beat bookkeeping
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_loading = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_full    = (w_cnt_inc == FULL_CNT);
  assign w_wr      = w_accept & w_loading;
  assign w_set_err = w_wr & (cfg_last ^ w_full);
  assign w_swap    = (r_state == S_ARMED) & sample_strobe;
  assign w_idx     = r_cnt[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (cfg_last) w_state_nxt = w_full ? S_ARMED : S_IDLE;
          else          w_state_nxt = w_full ? S_DRAIN : S_LOAD;
        end
      end
      S_DRAIN: if (w_accept && cfg_last) w_state_nxt = S_IDLE;
      S_ARMED: if (sample_strobe) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b1;
    busy      = 1'b1;
    if (r_state == S_ARMED) cfg_ready = 1'b0;
    if (r_state == S_IDLE)  busy      = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (w_state_nxt == S_IDLE) r_cnt <= '0;
    else if (w_wr)                  r_cnt <= w_cnt_inc;
  end

  // Only the shadow bank is ever written; the active one changes by swapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ORDER; k++) begin
        r_bank0[k] <= '0;
        r_bank1[k] <= '0;
      end
    end else if (w_wr) begin
      if (r_bank_sel) r_bank0[w_idx] <= cfg_data;
      else            r_bank1[w_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bank_sel  <= 1'b0;
      r_flush     <= 1'b0;
      r_swap_done <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_bank_sel  <= r_bank_sel ^ w_swap;
      r_flush     <= w_swap & flush_en;
      r_swap_done <= w_swap;
      r_cfg_err   <= w_set_err;
    end
  end

  always_comb begin
    coeff_bus = '0;
    for (int k = 0; k < ORDER; k++) begin
      coeff_bus[k*COEFF_W +: COEFF_W] = r_bank_sel ? r_bank1[k] : r_bank0[k];
    end
  end

  assign bank_sel  = r_bank_sel;
  assign flush     = r_flush;
  assign swap_done = r_swap_done;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb/tb_fir_coeff_ctrl.sv - scenario table, corner sequences and random run against a set-level model
module tb_fir_coeff_ctrl;

  localparam int ORDER   = 64;
  localparam int COEFF_W = 32;
  localparam int CNT_W   = 7;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     cfg_valid = 1'b0;
  logic                     cfg_ready;
  logic [COEFF_W-1:0]       cfg_data = '0;
  logic                     cfg_last = 1'b0;
  logic                     sample_strobe = 1'b0;
  logic                     flush_en = 1'b0;
  logic [ORDER*COEFF_W-1:0] coeff_bus;
  logic                     bank_sel;
  logic                     flush;
  logic                     swap_done;
  logic                     cfg_err;
  logic                     busy;

  fir_coeff_ctrl #(.ORDER(ORDER), .COEFF_W(COEFF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .sample_strobe(sample_strobe),
    .flush_en(flush_en), .coeff_bus(coeff_bus), .bank_sel(bank_sel), .flush(flush),
    .swap_done(swap_done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Set-level model: a set is the list of beats between cfg_last markers
  logic [COEFF_W-1:0] m_active [ORDER];
  logic [COEFF_W-1:0] m_pending [ORDER];
  logic [COEFF_W-1:0] m_set [$];
  bit m_bank, m_armed, m_bad;
  int m_n;
  bit e_err, e_swap, e_flush;
  int n_err, n_swap, n_flush;

  typedef struct {
    int len;
    bit coinc;
    bit fl;
    int exp_err;
    int exp_swap;
    int exp_flush;
    bit exp_bank;
    int exp_tap0;
  } vec_t;

  vec_t tbl [8];

  function automatic void model_reset();
    for (int k = 0; k < ORDER; k++) m_active[k] = '0;
    m_set.delete();
    m_bank = 0; m_armed = 0; m_bad = 0; m_n = 0;
    e_err = 0; e_swap = 0; e_flush = 0;
  endfunction

  function automatic void model_edge(bit v, logic [COEFF_W-1:0] d, bit l, bit s, bit f);
    e_err = 0; e_swap = 0; e_flush = 0;
    if (m_armed) begin
      if (s) begin
        for (int k = 0; k < ORDER; k++) m_active[k] = m_pending[k];
        m_bank = !m_bank;
        e_swap = 1;
        e_flush = f;
        m_armed = 0;
      end
    end else if (v) begin
      m_n++;
      if (!m_bad) m_set.push_back(d);
      if (l) begin
        if (!m_bad) begin
          if (m_n == ORDER) begin
            for (int k = 0; k < ORDER; k++) m_pending[k] = m_set[k];
            m_armed = 1;
          end else begin
            e_err = 1;
          end
        end
        m_set.delete();
        m_n = 0;
        m_bad = 0;
      end else if (m_n == ORDER && !m_bad) begin
        e_err = 1;
        m_bad = 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_bus(input string nm);
    int bad_tap;
    bad_tap = -1;
    for (int k = ORDER - 1; k >= 0; k--)
      if (coeff_bus[k*COEFF_W +: COEFF_W] !== m_active[k]) bad_tap = k;
    checks++;
    if (bad_tap >= 0) begin
      errors++;
      $display("FAIL %s at %0t: tap %0d got %h want %h", nm, $time, bad_tap,
               coeff_bus[bad_tap*COEFF_W +: COEFF_W], m_active[bad_tap]);
    end
  endtask

  task automatic compare_all();
    chk("cfg_ready", int'(cfg_ready), int'(!m_armed));
    chk("busy", int'(busy), int'(m_armed || m_n > 0));
    chk("bank_sel", int'(bank_sel), int'(m_bank));
    chk("cfg_err", int'(cfg_err), int'(e_err));
    chk("swap_done", int'(swap_done), int'(e_swap));
    chk("flush", int'(flush), int'(e_flush));
    chk_bus("coeff_bus");
  endtask

  // Called at posedge+1; drives one cycle and checks the result after the edge
  task automatic cyc(input bit v, input logic [COEFF_W-1:0] d, input bit l, input bit s, input bit f);
    cfg_valid = v; cfg_data = d; cfg_last = l; sample_strobe = s; flush_en = f;
    @(posedge clk);
    model_edge(v, d, l, s, f);
    #1;
    if (cfg_err) n_err++;
    if (swap_done) n_swap++;
    if (flush) n_flush++;
    compare_all();
  endtask

  task automatic do_reset(input int hold);
    cfg_valid = 0; cfg_last = 0; sample_strobe = 0; flush_en = 0;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_set(input int len, input int base, input bit coinc, input bit fl);
    n_err = 0; n_swap = 0; n_flush = 0;
    for (int i = 0; i < len; i++)
      cyc(1'b1, COEFF_W'(base + i), i == len - 1, coinc && (i == len - 1), fl);
    cyc(1'b0, '0, 1'b0, 1'b0, fl);
    cyc(1'b0, '0, 1'b0, 1'b0, fl);
    cyc(1'b0, '0, 1'b0, 1'b1, fl);
    cyc(1'b0, '0, 1'b0, 1'b0, fl);
    cyc(1'b0, '0, 1'b0, 1'b0, fl);
  endtask

  initial begin
    logic [COEFF_W-1:0] set_b [ORDER];
    int tgt;
    bit v, l;

    tbl[0] = '{64, 1'b0, 1'b1, 0, 1, 1, 1'b1, 1};
    tbl[1] = '{10, 1'b0, 1'b0, 1, 0, 0, 1'b1, 1};
    tbl[2] = '{70, 1'b0, 1'b1, 1, 0, 0, 1'b1, 1};
    tbl[3] = '{64, 1'b1, 1'b0, 0, 1, 0, 1'b0, 769};
    tbl[4] = '{1,  1'b0, 1'b1, 1, 0, 0, 1'b0, 769};
    tbl[5] = '{63, 1'b0, 1'b1, 1, 0, 0, 1'b0, 769};
    tbl[6] = '{65, 1'b0, 1'b0, 1, 0, 0, 1'b0, 769};
    tbl[7] = '{64, 1'b0, 1'b0, 0, 1, 0, 1'b1, 1793};

    do_reset(3);
    chk("reset_bus_zero", int'(coeff_bus == '0), 1);

    for (int i = 0; i < 8; i++) begin
      run_set(tbl[i].len, i * 256 + 1, tbl[i].coinc, tbl[i].fl);
      chk($sformatf("tbl%0d_err", i), n_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_swap", i), n_swap, tbl[i].exp_swap);
      chk($sformatf("tbl%0d_flush", i), n_flush, tbl[i].exp_flush);
      chk($sformatf("tbl%0d_bank", i), int'(bank_sel), int'(tbl[i].exp_bank));
      chk($sformatf("tbl%0d_tap0", i), int'(coeff_bus[0 +: COEFF_W]), tbl[i].exp_tap0);
      chk($sformatf("tbl%0d_tap63", i), int'(coeff_bus[(ORDER-1)*COEFF_W +: COEFF_W]),
          tbl[i].exp_tap0 + ORDER - 1);
    end

    // Reset mid-load, then a fresh set must land exactly
    for (int i = 0; i < 30; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    for (int k = 0; k < ORDER; k++) set_b[k] = $urandom;
    for (int k = 0; k < ORDER; k++) cyc(1'b1, set_b[k], k == ORDER - 1, 1'b0, 1'b0);
    chk("armed_not_ready", int'(cfg_ready), 0);
    chk("armed_bank_old", int'(bank_sel), 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("midreset_bank", int'(bank_sel), 1);
    for (int k = 0; k < ORDER; k++)
      if (coeff_bus[k*COEFF_W +: COEFF_W] !== set_b[k])
        chk($sformatf("midreset_tap%0d", k), int'(coeff_bus[k*COEFF_W +: COEFF_W]), int'(set_b[k]));
    chk("midreset_tap_last", int'(coeff_bus[(ORDER-1)*COEFF_W +: COEFF_W]), int'(set_b[ORDER-1]));

    // Reset while armed loses the pending swap
    run_set(64, 5000, 1'b0, 1'b0);
    for (int k = 0; k < ORDER; k++) cyc(1'b1, COEFF_W'(k + 9000), k == ORDER - 1, 1'b0, 1'b0);
    do_reset(1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("armed_reset_bank", int'(bank_sel), 0);
    chk("armed_reset_tap5", int'(coeff_bus[5*COEFF_W +: COEFF_W]), 0);

    // Random traffic with bubbles, odd set lengths and stray strobes
    tgt = ORDER;
    for (int c = 0; c < 3000; c++) begin
      if (m_n == 0 && !m_armed)
        tgt = ($urandom % 4 < 2) ? ORDER : int'($urandom_range(1, 72));
      v = ($urandom % 4) != 0;
      l = v && (m_n == tgt - 1);
      cyc(v, $urandom, l, ($urandom % 6) == 0, $urandom % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
